// File: rtl/ser_pkg.sv
// Shared types and constants for the ser_ctrl parallel-in/serial-out sequencer.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FIN
  } state_t;

  localparam int W_MIN = 2;
  localparam int W_MAX = 32;

endpackage

// File: rtl/dff.sv
// Plain single-bit D flip-flop with no reset; clearing is done by the D-side mux.
module dff (
  input  logic clk,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    q <= d;
  end

endmodule

// File: rtl/shift_chain.sv
// Chain of W dff cells, each fed by a clear/load/shift/hold mux on its D input.
module shift_chain #(
  parameter int W         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] data,
  output logic         out_bit
);

  logic [W-1:0] q;
  logic [W-1:0] d;
  logic [W-1:0] shifted;

  // Bits move toward whichever end feeds the serial output; the far end fills with 0.
  assign shifted = LSB_FIRST ? {1'b0, q[W-1:1]} : {q[W-2:0], 1'b0};

  always_comb begin
    if (clear) begin
      d = '0;
    end else if (load) begin
      d = data;
    end else if (shift) begin
      d = shifted;
    end else begin
      d = q;
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_cell
    dff u_dff (
      .clk (clk),
      .d   (d[i]),
      .q   (q[i])
    );
  end

  assign out_bit = LSB_FIRST ? q[0] : q[W-1];

endmodule

// File: rtl/ser_ctrl.sv
// Sequencer: accepts a word on the load handshake, then streams it bit by bit on the serial handshake.
module ser_ctrl
  import ser_pkg::*;
#(
  parameter int W         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         C,
  input  logic         R,
  input  logic [W-1:0] LD_DATA,
  input  logic         LD_VALID,
  output logic         LD_READY,
  output logic         SO,
  output logic         SO_VALID,
  input  logic         SO_READY,
  output logic         BUSY,
  output logic         DONE
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          do_load;
  logic          do_shift;
  logic          chain_out;

  always_ff @(posedge C) begin
    if (R) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_shift   = 1'b0;
    case (state)
      IDLE: begin
        if (LD_VALID) begin
          do_load    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (SO_READY) begin
          do_shift = 1'b1;
          if (cnt == LAST) begin
            state_next = FIN;
          end
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The counter parks at LAST on the final shift so it only returns to 0 through a reload.
  always_ff @(posedge C) begin
    if (R || do_load) begin
      cnt <= '0;
    end else if (do_shift && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  shift_chain #(
    .W         (W),
    .LSB_FIRST (LSB_FIRST)
  ) u_chain (
    .clk     (C),
    .clear   (R),
    .load    (do_load),
    .shift   (do_shift),
    .data    (LD_DATA),
    .out_bit (chain_out)
  );

  assign LD_READY = (state == IDLE);
  assign SO_VALID = (state == SHIFT);
  assign SO       = (state == SHIFT) & chain_out;
  assign BUSY     = (state != IDLE);
  assign DONE     = (state == FIN);

endmodule
